mux2a1_dest_arb: RTL and testbench
==================================

# mux2a1_dest_arb

Merging multiplexer that recombines two per-destination 8-bit lanes (dest 0 and dest 1) into a single stream. It is the return path of the 1-to-2 destination routing demux. Each lane has a one-entry holding register with a valid/ready handshake. A round-robin arbiter picks which held word moves into a registered output stage. The chosen lane index is re-emitted as `dest_out`, so the demux output can be fed straight back in for loopback checks.

## Interface
Parameters:
- `WIDTH`, 8, data width of every lane and of the output

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_L`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`
- `datain0`  in  WIDTH  lane 0 (dest 0) data
- `valid0`  in  1  lane 0 data valid
- `ready0`  out  1  lane 0 can accept this cycle
- `datain1`  in  WIDTH  lane 1 (dest 1) data
- `valid1`  in  1  lane 1 data valid
- `ready1`  out  1  lane 1 can accept this cycle
- `dataout`  out  WIDTH  merged output data (registered)
- `valid_out`  out  1  `dataout`/`dest_out` hold a word
- `dest_out`  out  1  lane the current output word came from
- `ready_in`  in  1  downstream accepts the output word this cycle
- `count0`  out  8  words delivered from lane 0, wraps 255→0
- `count1`  out  8  words delivered from lane 1, wraps 255→0

## Operation
- **Holding registers:** each lane has `hold_i` (WIDTH bits) and a flag `hv_i`.
  - An accept on lane i occurs when `valid_i & ready_i` at an edge.
  - On accept, `hold_i` is loaded and `hv_i` is set.
- **Advance:** `adv = ~valid_out | ready_in`. Output-stage transfers happen only when `adv` = 1.
- **Grant:** one lane is granted per cycle, only if `adv` and at least one `hv_i` is set.
  - Only one lane flagged: that lane is granted.
  - Both flagged: the lane not equal to `last` is granted, where `last` is the lane granted most recently (round-robin).
- **Granted transfer at the edge:**
  - `dataout` ← `hold_g`, `dest_out` ← g, `valid_out` ← 1.
  - `last` ← g; `count_g` is incremented.
  - `hv_g` is cleared, unless a new accept on lane g happens in the same cycle, in which case `hv_g` stays 1 with the new data.
- **Drain without grant:** if `adv` = 1, `ready_in` = 1, and nothing is granted, `valid_out` ← 0. `dataout` and `dest_out` hold their last values.
- **Stall:** if `valid_out` = 1 and `ready_in` = 0, all output-stage registers hold.
- **Ready (combinational, no dependency on `valid_i`):** `ready_i = ~hv_i | (grant_i & adv)`. A full, granted lane therefore accepts back-to-back.
- **Counters:** `count_i` increments on the grant, not on downstream consumption. An 8-bit wrap is normal behaviour, not an error.

## Timing
- **Reset** (`reset_L` = 0 at an edge), from the next cycle onward:
  - `dataout` = 0, `dest_out` = 0, `valid_out` = 0, `count0` = `count1` = 0.
  - `hv0` = `hv1` = 0, so `ready0` = `ready1` = 1. `last` = 1, so lane 0 wins the first tie.
- **Reset mid-operation:** held and output words are discarded with no partial output. An accept in the reset cycle is ignored.
- **Latency:** a word accepted at edge N appears on `dataout` after edge N+1 if uncontested and `adv` = 1. Each cycle lost to arbitration or stall adds one cycle.
- **Throughput:** one word per cycle sustained. With both lanes continuously valid and `ready_in` = 1, the output alternates 0,1,0,1…
- **Back-pressure:** a word waits at most one grant behind the other lane once `ready_in` returns high; no starvation.
- **Simultaneous events:** a grant and a new accept on the same lane in one cycle is legal; no word is lost or duplicated.
- **Stability:** `valid_out`, `dataout`, and `dest_out` change only at edges.

## Configuration
- `FIXED_PRIO_EN`:
  - When defined, lane 0 has strict priority. With both `hv` set, lane 0 is always granted; `last` is still updated but ignored. Lane 1 can starve while lane 0 stays continuously valid.
  - When undefined, round-robin arbitration applies as specified above.
  - All other behaviour and timing is identical in both builds.

## Test plan
- **Reset:** hold `reset_L` = 0 for 2 cycles with `valid0` = `valid1` = 1 → all outputs 0, `ready0` = `ready1` = 1, nothing captured.
- **Single lane:** `datain0` = 0x0F, `valid0` = 1 for one cycle, `ready_in` = 1 → `dataout` = 0x0F, `dest_out` = 0, `valid_out` = 1 two edges later; `count0` = 1; `valid_out` returns to 0 the next cycle.
- **Contention:** lanes 0/1 both valid for 4 cycles with 0x01–0x04 and 0x11–0x14, `ready_in` = 1 → output sequence 0x01(0), 0x11(1), 0x02(0), 0x12(1)…; `count0` = `count1` = 4 at the end. Under `FIXED_PRIO_EN`, all lane 0 words come first.
- **Back-pressure:** `ready_in` = 0 for 3 cycles while output is valid with 0x07 → `dataout` holds 0x07, both lanes fill, then `ready0` = `ready1` = 0; on `ready_in` = 1, remaining words emerge in round-robin order with none lost.
- **Wrap:** 256 lane 1 words → `count1` = 0, `count0` unchanged.
- **Mid-stream reset:** assert `reset_L` = 0 while both lanes are held and the output is stalled → next cycle `valid_out` = 0, counters 0, and the first tie after release goes to lane 0.

Source files
------------

// File: rtl/mux2a1_dest_arb.sv
// Two-lane merge: per-lane one-entry hold registers, round-robin arbiter, registered output stage.
// Define FIXED_PRIO_EN to give lane 0 strict priority instead of round-robin.
module mux2a1_dest_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] datain0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [WIDTH-1:0] datain1,
    input  logic             valid1,
    output logic             ready1,
    output logic [WIDTH-1:0] dataout,
    output logic             valid_out,
    output logic             dest_out,
    input  logic             ready_in,
    output logic [7:0]       count0,
    output logic [7:0]       count1
);

    // Handshake: a word moves on any edge where valid and ready are both high;
    // ready never depends on the matching valid, and valid_out/dataout/dest_out
    // stay stable while valid_out is high and ready_in is low.
    logic [WIDTH-1:0] hold0, hold1;
    logic             hv0, hv1;
    logic             last;
    logic             adv;
    logic             grant0, grant1;
    logic             acc0, acc1;

    always_comb begin
        adv    = ~valid_out | ready_in;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (adv) begin
            if (hv0 && hv1) begin
`ifdef FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                // last == 1 means lane 1 went most recently, so lane 0 wins.
                grant0 = last;
                grant1 = ~last;
`endif
            end else begin
                grant0 = hv0;
                grant1 = hv1;
            end
        end
        ready0 = ~hv0 | grant0;
        ready1 = ~hv1 | grant1;
        acc0   = valid0 & ready0;
        acc1   = valid1 & ready1;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            hold0     <= '0;
            hold1     <= '0;
            hv0       <= 1'b0;
            hv1       <= 1'b0;
            last      <= 1'b1;
            dataout   <= '0;
            dest_out  <= 1'b0;
            valid_out <= 1'b0;
            count0    <= 8'd0;
            count1    <= 8'd0;
        end else begin
            // A fresh accept wins over the clear, so a granted lane refills in place.
            if (acc0) begin
                hold0 <= datain0;
                hv0   <= 1'b1;
            end else if (grant0) begin
                hv0 <= 1'b0;
            end
            if (acc1) begin
                hold1 <= datain1;
                hv1   <= 1'b1;
            end else if (grant1) begin
                hv1 <= 1'b0;
            end

            if (grant0 || grant1) begin
                valid_out <= 1'b1;
                dest_out  <= grant1;
                dataout   <= grant1 ? hold1 : hold0;
                last      <= grant1;
                if (grant1) count1 <= count1 + 8'd1;
                else        count0 <= count0 + 8'd1;
            end else if (adv && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2a1_dest_arb.sv
// Bench for mux2a1_dest_arb: lane sources, queue-based reference model and output scoreboard.
module tb_mux2a1_dest_arb;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_L;
    logic [W-1:0] datain0, datain1, dataout;
    logic         valid0, valid1, ready0, ready1;
    logic         valid_out, dest_out, ready_in;
    logic [7:0]   count0, count1;

    always #5 clk = ~clk;

    mux2a1_dest_arb #(.WIDTH(W)) dut (
        .clk(clk), .reset_L(reset_L),
        .datain0(datain0), .valid0(valid0), .ready0(ready0),
        .datain1(datain1), .valid1(valid1), .ready1(ready1),
        .dataout(dataout), .valid_out(valid_out), .dest_out(dest_out),
        .ready_in(ready_in), .count0(count0), .count1(count1)
    );

    int tests = 0;
    int fails = 0;

    // Sources: words waiting to be offered on each lane.
    logic [W-1:0] src0[$], src1[$];
    // Reference model: lane holding queues (0 or 1 entries), output word, arbitration memory.
    logic [W-1:0] lane0_q[$], lane1_q[$];
    logic         m_vout;
    logic [W-1:0] m_data;
    logic         m_dest;
    int           m_last;
    int           m_cnt[2];
    // Scoreboard of words entering the output stage, in order, tagged with lane.
    logic [W:0]   exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit adv_now);
        bit f0, f1;
        f0 = lane0_q.size() != 0;
        f1 = lane1_q.size() != 0;
        if (!adv_now || (!f0 && !f1)) return -1;
        if (f0 && f1) begin
`ifdef FIXED_PRIO_EN
            return 0;
`else
            return (m_last == 0) ? 1 : 0;
`endif
        end
        return f0 ? 0 : 1;
    endfunction

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step(input bit rst_n, input bit rin, input bit en0, input bit en1);
        bit adv, r0, r1, v0, v1;
        int g;
        logic [W-1:0] d0, d1;
        v0 = rst_n ? (en0 && src0.size() != 0) : 1'b1;
        v1 = rst_n ? (en1 && src1.size() != 0) : 1'b1;
        d0 = (rst_n && src0.size() != 0) ? src0[0] : W'($urandom_range(0, 255));
        d1 = (rst_n && src1.size() != 0) ? src1[0] : W'($urandom_range(0, 255));
        reset_L = rst_n; ready_in = rin;
        valid0 = v0; datain0 = d0; valid1 = v1; datain1 = d1;
        #1;
        adv = !m_vout || rin;
        g   = pick(adv);
        r0  = (lane0_q.size() == 0) || (g == 0);
        r1  = (lane1_q.size() == 0) || (g == 1);
        check("ready0", 32'(ready0), 32'(r0));
        check("ready1", 32'(ready1), 32'(r1));
        if (rst_n && valid_out && rin) begin
            if (exp_q.size() == 0) check("sb_size", exp_q.size(), 1);
            else check("sb_word", 32'({dest_out, dataout}), 32'(exp_q.pop_front()));
        end
        if (!rst_n) begin
            lane0_q.delete(); lane1_q.delete(); exp_q.delete();
            m_vout = 1'b0; m_data = '0; m_dest = 1'b0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            if (g >= 0) begin
                m_data = (g == 1) ? lane1_q.pop_front() : lane0_q.pop_front();
                m_dest = (g == 1);
                m_vout = 1'b1;
                m_last = g;
                m_cnt[g] = (m_cnt[g] + 1) % 256;
                exp_q.push_back({m_dest, m_data});
            end else if (adv) begin
                m_vout = 1'b0;
            end
            if (v0 && r0) begin lane0_q.push_back(d0); void'(src0.pop_front()); end
            if (v1 && r1) begin lane1_q.push_back(d1); void'(src1.pop_front()); end
        end
        @(posedge clk);
        @(negedge clk);
        check("valid_out", 32'(valid_out), 32'(m_vout));
        check("dataout",   32'(dataout),   32'(m_data));
        check("dest_out",  32'(dest_out),  32'(m_dest));
        check("count0",    32'(count0),    32'(m_cnt[0]));
        check("count1",    32'(count1),    32'(m_cnt[1]));
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (src0.size() + src1.size() + lane0_q.size() + lane1_q.size()) != 0; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        reset_L = 1'b0; ready_in = 1'b0;
        valid0 = 1'b1; valid1 = 1'b1; datain0 = 8'hAA; datain1 = 8'h55;
        m_vout = 1'b0; m_data = '0; m_dest = 1'b0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with both lanes offering data.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_count0", 32'(count0), 32'd0);

        // Single lane word: visible two edges after it is offered.
        src0.push_back(8'h0F);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("single_data", 32'(dataout), 32'h0F);
        check("single_dest", 32'(dest_out), 32'd0);
        check("single_count0", 32'(count0), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("single_drop", 32'(valid_out), 32'd0);

        // Contention between the lanes.
        for (int i = 1; i <= 4; i++) begin
            src0.push_back(W'(i));
            src1.push_back(W'(8'h10 + i));
        end
        drain();
        check("cont_count0", 32'(count0), 32'd5);
        check("cont_count1", 32'(count1), 32'd4);

        // Back-pressure: output held at 0x07 while both lanes fill up.
        src0.push_back(8'h07);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        src0.push_back(8'h08);
        src1.push_back(8'h18);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        check("bp_hold", 32'(dataout), 32'h07);
        check("bp_ready0", 32'(ready0), 32'd0);
        check("bp_ready1", 32'(ready1), 32'd0);
        drain();

        // Lane 1 counter wrap.
        for (int i = 0; i < 256; i++) src1.push_back(W'(i));
        drain();
        check("wrap_count1", 32'(count1), 32'd5);
        check("wrap_count0", 32'(count0), 32'd7);

        // Random traffic with random gaps and back-pressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) src0.push_back(W'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) src1.push_back(W'($urandom_range(0, 255)));
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset while both lanes are held and the output is stalled.
        src0.push_back(8'h21); src0.push_back(8'h22);
        src1.push_back(8'h31); src1.push_back(8'h32);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        src0.delete(); src1.delete();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("mrst_valid_out", 32'(valid_out), 32'd0);
        check("mrst_count1", 32'(count1), 32'd0);
        src0.push_back(8'h41); src1.push_back(8'h51);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mrst_tie_dest", 32'(dest_out), 32'd0);
        check("mrst_tie_data", 32'(dataout), 32'h41);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
